// File: rtl/sec_to_hms_pkg.sv
// Shared constants and state encoding for the seconds-of-day to BCD HH:MM:SS converter.
package sec_to_hms_pkg;

  localparam int SEC_PER_HOUR = 3600;
  localparam int SEC_PER_MIN  = 60;
  localparam int SEC_PER_DAY  = 86400;
  localparam int DIGIT_W      = 4;
  localparam int REM_W        = 17;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOUR = 3'd1,
    ST_MIN  = 3'd2,
    ST_SEC  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/sec_to_hms_bcd2_inc.sv
// Two-digit packed BCD counter with synchronous clear and increment enable.
module bcd2_inc
  import sec_to_hms_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   inc,
  output logic [2*DIGIT_W-1:0]   value
);

  // Units roll 9 -> 0 and carry into tens; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 8'h00;
    end else if (clr) begin
      value <= 8'h00;
    end else if (inc) begin
      if (value[3:0] == 4'd9) begin
        value <= {value[7:4] + 4'd1, 4'd0};
      end else begin
        value <= {value[7:4], value[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/sec_to_hms.sv
// Converts a seconds-of-day value into packed BCD hours/minutes/seconds by repeated subtraction.
module sec_to_hms #(
  parameter int IN_WIDTH    = 32,
  parameter int SEC_PER_DAY = sec_to_hms_pkg::SEC_PER_DAY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] sec_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [7:0]          hh_bcd,
  output logic [7:0]          mm_bcd,
  output logic [7:0]          ss_bcd
);

  import sec_to_hms_pkg::*;

  state_t             state_r;
  logic [REM_W-1:0]   rem_r;
  logic [DIGIT_W-1:0] sec_tens_r;
  logic [7:0]         hour_s;
  logic [7:0]         min_s;
  logic               in_range_s;
  logic               accept_s;
  logic               hour_step_s;
  logic               min_step_s;

  // Range check uses the full-width input, before truncation to the remainder width.
  assign in_range_s  = (sec_in < IN_WIDTH'(SEC_PER_DAY));
  assign accept_s    = (state_r == ST_IDLE) && start;
  assign hour_step_s = (state_r == ST_HOUR) && (rem_r >= REM_W'(SEC_PER_HOUR));
  assign min_step_s  = (state_r == ST_MIN)  && (rem_r >= REM_W'(SEC_PER_MIN));

  bcd2_inc u_hour (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept_s && in_range_s),
    .inc   (hour_step_s),
    .value (hour_s)
  );

  bcd2_inc u_min (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept_s && in_range_s),
    .inc   (min_step_s),
    .value (min_s)
  );

  // Conversion FSM; results and done are registered on leaving SEC/ERR so they are live in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rem_r      <= 17'd0;
      sec_tens_r <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      hh_bcd     <= 8'h00;
      mm_bcd     <= 8'h00;
      ss_bcd     <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (in_range_s) begin
              rem_r      <= sec_in[REM_W-1:0];
              sec_tens_r <= 4'd0;
              state_r    <= ST_HOUR;
            end else begin
              state_r <= ST_ERR;
            end
          end
        end
        ST_HOUR: begin
          if (hour_step_s) begin
            rem_r <= rem_r - REM_W'(SEC_PER_HOUR);
          end else begin
            state_r <= ST_MIN;
          end
        end
        ST_MIN: begin
          if (min_step_s) begin
            rem_r <= rem_r - REM_W'(SEC_PER_MIN);
          end else begin
            state_r <= ST_SEC;
          end
        end
        ST_SEC: begin
          if (rem_r >= 17'd10) begin
            rem_r      <= rem_r - 17'd10;
            sec_tens_r <= sec_tens_r + 4'd1;
          end else begin
            hh_bcd  <= hour_s;
            mm_bcd  <= min_s;
            ss_bcd  <= {sec_tens_r, rem_r[3:0]};
            err     <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_ERR: begin
          err     <= 1'b1;
          done    <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
